// File: rtl/armleocpu_ptw_sequencer_if.sv
// Bundle of the walker's request/response and memory-read signals.
// The slave modport is the walker's view; master is the cache/memory side.
interface armleocpu_ptw_sequencer_if;
    logic        satp_mode;
    logic [21:0] satp_ppn;
    logic        resolve_request;
    logic [19:0] resolve_virtual_address;
    logic        resolve_ack;
    logic        resolve_done;
    logic        resolve_pagefault;
    logic        resolve_accessfault;
    logic [21:0] resolve_physical_address;
    logic [7:0]  resolve_metadata;
    logic        mem_valid;
    logic        mem_ready;
    logic [33:0] mem_address;
    logic        mem_rvalid;
    logic [1:0]  mem_rresp;
    logic [31:0] mem_rdata;

    modport master (
        output satp_mode, satp_ppn, resolve_request, resolve_virtual_address,
        output mem_ready, mem_rvalid, mem_rresp, mem_rdata,
        input  resolve_ack, resolve_done, resolve_pagefault, resolve_accessfault,
        input  resolve_physical_address, resolve_metadata, mem_valid, mem_address
    );

    modport slave (
        input  satp_mode, satp_ppn, resolve_request, resolve_virtual_address,
        input  mem_ready, mem_rvalid, mem_rresp, mem_rdata,
        output resolve_ack, resolve_done, resolve_pagefault, resolve_accessfault,
        output resolve_physical_address, resolve_metadata, mem_valid, mem_address
    );
endinterface

// File: rtl/armleocpu_ptw_sequencer.sv
// Sv32 two-level page-table walker for the TLB-miss path. Single outstanding
// PTE read; only structural PTE checks are made here.
module armleocpu_ptw_sequencer (
    input  logic clk,
    input  logic rst,
    armleocpu_ptw_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic        level_r, level_s;
    logic [21:0] base_r, base_s;
    logic [19:0] vpn_r, vpn_s;
    logic        pagefault_r, pagefault_s;
    logic        accessfault_r, accessfault_s;
    logic [21:0] ppn_r, ppn_s;
    logic [7:0]  metadata_r, metadata_s;
    logic        ack_s;

    logic [31:0] pte_s;
    logic        pte_v_s, pte_r_s, pte_w_s, pte_x_s;
    logic        unused_rsw_s;

    assign pte_s        = bus.mem_rdata;
    assign pte_v_s      = pte_s[0];
    assign pte_r_s      = pte_s[1];
    assign pte_w_s      = pte_s[2];
    assign pte_x_s      = pte_s[3];
    assign unused_rsw_s = ^pte_s[9:8];

    // Next-state and walk decisions; PTE is evaluated in the cycle rvalid arrives
    always_comb begin
        state_s       = state_r;
        level_s       = level_r;
        base_s        = base_r;
        vpn_s         = vpn_r;
        pagefault_s   = pagefault_r;
        accessfault_s = accessfault_r;
        ppn_s         = ppn_r;
        metadata_s    = metadata_r;
        ack_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.resolve_request) begin
                    ack_s         = 1'b1;
                    vpn_s         = bus.resolve_virtual_address;
                    base_s        = bus.satp_ppn;
                    level_s       = 1'b1;
                    pagefault_s   = 1'b0;
                    accessfault_s = 1'b0;
                    if (bus.satp_mode) begin
                        ppn_s      = 22'd0;
                        metadata_s = 8'd0;
                        state_s    = ISSUE;
                    end else begin
                        // Bare mode: identity map with full access tag
                        ppn_s      = {2'b00, bus.resolve_virtual_address};
                        metadata_s = 8'b1101_1111;
                        state_s    = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (bus.mem_ready) begin
                    state_s = WAIT;
                end else begin
                    state_s = ISSUE;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    if (bus.mem_rresp != 2'd0) begin
                        accessfault_s = 1'b1;
                        state_s       = DONE;
                    end else if (!pte_v_s || (!pte_r_s && pte_w_s)) begin
                        pagefault_s = 1'b1;
                        state_s     = DONE;
                    end else if (pte_r_s || pte_x_s) begin
                        if (level_r && (pte_s[19:10] != 10'd0)) begin
                            pagefault_s = 1'b1;
                        end else begin
                            ppn_s      = level_r ? {pte_s[31:20], vpn_r[9:0]} : pte_s[31:10];
                            metadata_s = pte_s[7:0];
                        end
                        state_s = DONE;
                    end else if (!level_r) begin
                        pagefault_s = 1'b1;
                        state_s     = DONE;
                    end else begin
                        base_s  = pte_s[31:10];
                        level_s = 1'b0;
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            level_r       <= 1'b0;
            base_r        <= 22'd0;
            vpn_r         <= 20'd0;
            pagefault_r   <= 1'b0;
            accessfault_r <= 1'b0;
            ppn_r         <= 22'd0;
            metadata_r    <= 8'd0;
        end else begin
            state_r       <= state_s;
            level_r       <= level_s;
            base_r        <= base_s;
            vpn_r         <= vpn_s;
            pagefault_r   <= pagefault_s;
            accessfault_r <= accessfault_s;
            ppn_r         <= ppn_s;
            metadata_r    <= metadata_s;
        end
    end

    // Outputs decode from registered state so reset clears them at once
    assign bus.resolve_ack              = ack_s && !rst;
    assign bus.resolve_done             = (state_r == DONE);
    assign bus.resolve_pagefault        = pagefault_r;
    assign bus.resolve_accessfault      = accessfault_r;
    assign bus.resolve_physical_address = ppn_r;
    assign bus.resolve_metadata         = metadata_r;
    assign bus.mem_valid                = (state_r == ISSUE);
    assign bus.mem_address              = {base_r, (level_r ? vpn_r[19:10] : vpn_r[9:0]), 2'b00};

endmodule

// File: tb/tb_armleocpu_ptw_sequencer.sv
// Randomized bench for the Sv32 walker: a sparse page-table memory, a
// reference walk model and a bus responder with random stalls and latency.
module tb_armleocpu_ptw_sequencer;

    logic clk;
    logic rst;
    armleocpu_ptw_sequencer_if ptw_if();

    armleocpu_ptw_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (ptw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem_tbl [logic [33:0]];
    bit          err_tbl [logic [33:0]];
    logic [33:0] exp_q [$];
    logic        exp_pf, exp_af;
    logic [21:0] exp_pa;
    logic [7:0]  exp_md;
    logic        got_pf, got_af;
    logic [21:0] got_pa;
    logic [7:0]  got_md;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [33:0] a);
        return mem_tbl.exists(a) ? mem_tbl[a] : 32'd0;
    endfunction

    // Reference walk: expected read addresses and final result
    task automatic model(input logic mode, input logic [21:0] ppn, input logic [19:0] vpn);
        logic [21:0] tbl;
        logic [33:0] a;
        logic [31:0] p;
        int lvl;
        exp_q.delete();
        exp_pf = 1'b0; exp_af = 1'b0; exp_pa = 22'd0; exp_md = 8'd0;
        if (!mode) begin
            exp_pa = 22'(vpn);
            exp_md = 8'hDF;
            return;
        end
        tbl = ppn;
        for (lvl = 1; lvl >= 0; lvl--) begin
            a = 34'(tbl) * 34'd4096 + 34'((lvl == 1) ? (vpn / 1024) : (vpn % 1024)) * 34'd4;
            exp_q.push_back(a);
            p = rd_mem(a);
            if (err_tbl.exists(a)) begin exp_af = 1'b1; return; end
            if (p[0] == 1'b0 || (p[1] == 1'b0 && p[2] == 1'b1)) begin exp_pf = 1'b1; return; end
            if (p[1] || p[3]) begin
                if (lvl == 1 && ((p / 1024) % 1024) != 0) begin exp_pf = 1'b1; return; end
                exp_pa = (lvl == 1) ? 22'((p / 1048576) * 1024 + (vpn % 1024)) : 22'(p / 1024);
                exp_md = p[7:0];
                return;
            end
            if (lvl == 0) begin exp_pf = 1'b1; return; end
            tbl = 22'(p / 1024);
        end
    endtask

    function automatic logic [31:0] rand_pte(input int kind);
        logic [31:0] p;
        int k;
        p = $urandom;
        k = $urandom_range(0, 4);
        case (kind)
            0: p[3:0] = 4'b0001;
            1, 2: begin
                p[0]   = 1'b1;
                p[3:1] = (k == 0) ? 3'b001 : (k == 1) ? 3'b011 : (k == 2) ? 3'b100 : (k == 3) ? 3'b101 : 3'b111;
                p[19:10] = (kind == 1) ? 10'd0 : 10'($urandom_range(1, 1023));
            end
            3: p[0] = 1'b0;
            default: p[3:0] = 4'b0101;
        endcase
        return p;
    endfunction

    // One request from accept to done, with responder and bus-rule checks
    task automatic do_walk(input logic mode, input logic [21:0] ppn, input logic [19:0] vpn, input int fixed_stall);
        bit rd_pending, addr_seen, got_done;
        int stall_left, lat_left, cyc;
        logic [33:0] held_addr, rd_addr, exp_a;
        model(mode, ppn, vpn);
        ptw_if.satp_mode = mode;
        ptw_if.satp_ppn = ppn;
        ptw_if.resolve_virtual_address = vpn;
        ptw_if.resolve_request = 1'b1;
        #1;
        check_eq("ack", ptw_if.resolve_ack, 1'b1);
        @(posedge clk); #1;
        ptw_if.resolve_request = 1'b0;
        ptw_if.satp_mode = 1'($urandom);
        ptw_if.satp_ppn = 22'($urandom);
        ptw_if.resolve_virtual_address = 20'($urandom);
        rd_pending = 0; addr_seen = 0; got_done = 0; lat_left = 0; held_addr = 34'd0; rd_addr = 34'd0;
        stall_left = (fixed_stall >= 0) ? fixed_stall : $urandom_range(0, 2);
        for (cyc = 0; cyc < 200 && !got_done; cyc++) begin
            ptw_if.mem_ready = 1'b0;
            ptw_if.mem_rvalid = 1'b0;
            ptw_if.mem_rresp = 2'd0;
            ptw_if.mem_rdata = $urandom;
            if (ptw_if.resolve_done) begin
                got_done = 1;
                got_pf = ptw_if.resolve_pagefault;
                got_af = ptw_if.resolve_accessfault;
                got_pa = ptw_if.resolve_physical_address;
                got_md = ptw_if.resolve_metadata;
                check_eq("pagefault", got_pf, exp_pf);
                check_eq("accessfault", got_af, exp_af);
                check_eq("phys_addr", got_pa, exp_pa);
                check_eq("metadata", got_md, exp_md);
                check_eq("reads_left", exp_q.size(), 0);
                if (!mode) check_eq("bare_latency", cyc, 0);
            end else if (rd_pending) begin
                check_eq("mem_valid_in_wait", ptw_if.mem_valid, 1'b0);
                if (lat_left > 0) begin
                    lat_left--;
                end else begin
                    ptw_if.mem_rvalid = 1'b1;
                    ptw_if.mem_rresp = err_tbl.exists(rd_addr) ? 2'd2 : 2'd0;
                    ptw_if.mem_rdata = rd_mem(rd_addr);
                    rd_pending = 0;
                end
            end else if (ptw_if.mem_valid) begin
                if (!addr_seen) begin
                    check_eq("extra_read", exp_q.size() != 0, 1'b1);
                    exp_a = (exp_q.size() != 0) ? exp_q.pop_front() : 34'd0;
                    check_eq("mem_address", ptw_if.mem_address, exp_a);
                    held_addr = ptw_if.mem_address;
                    addr_seen = 1;
                end else begin
                    check_eq("addr_stable", ptw_if.mem_address, held_addr);
                end
                if (stall_left > 0) begin
                    stall_left--;
                    ptw_if.resolve_virtual_address = 20'($urandom);
                    ptw_if.satp_ppn = 22'($urandom);
                end else begin
                    ptw_if.mem_ready = 1'b1;
                    rd_pending = 1;
                    rd_addr = held_addr;
                    addr_seen = 0;
                    lat_left = $urandom_range(0, 2);
                    stall_left = (fixed_stall >= 0) ? fixed_stall : $urandom_range(0, 2);
                end
            end
            @(posedge clk); #1;
        end
        ptw_if.mem_ready = 1'b0;
        ptw_if.mem_rvalid = 1'b0;
        check_eq("done_seen", got_done, 1'b1);
        check_eq("done_one_cycle", ptw_if.resolve_done, 1'b0);
        check_eq("result_held", ptw_if.resolve_physical_address, exp_pa);
    endtask

    task automatic clear_mem();
        mem_tbl.delete();
        err_tbl.delete();
    endtask

    initial begin
        logic [21:0] ppn;
        logic [19:0] vpn;
        logic [31:0] p1;
        logic [33:0] a1, a0;
        int k;
        rst = 1'b1;
        ptw_if.satp_mode = 1'b0;
        ptw_if.satp_ppn = 22'd0;
        ptw_if.resolve_request = 1'b0;
        ptw_if.resolve_virtual_address = 20'd0;
        ptw_if.mem_ready = 1'b0;
        ptw_if.mem_rvalid = 1'b0;
        ptw_if.mem_rresp = 2'd0;
        ptw_if.mem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mem_valid", ptw_if.mem_valid, 1'b0);
        check_eq("rst_done", ptw_if.resolve_done, 1'b0);
        check_eq("rst_ack", ptw_if.resolve_ack, 1'b0);
        check_eq("rst_results", {ptw_if.resolve_pagefault, ptw_if.resolve_accessfault,
                                 ptw_if.resolve_physical_address, ptw_if.resolve_metadata}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset while a read is being requested
        clear_mem();
        ptw_if.satp_mode = 1'b1; ptw_if.satp_ppn = 22'h000100;
        ptw_if.resolve_virtual_address = 20'h00402; ptw_if.resolve_request = 1'b1;
        @(posedge clk); #1;
        ptw_if.resolve_request = 1'b0;
        check_eq("issue_mem_valid", ptw_if.mem_valid, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("midrst_mem_valid", ptw_if.mem_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        ptw_if.mem_rvalid = 1'b1; ptw_if.mem_rdata = 32'h0004_0001;
        @(posedge clk); #1;
        ptw_if.mem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("stale_no_done", ptw_if.resolve_done, 1'b0);
            check_eq("stale_no_valid", ptw_if.mem_valid, 1'b0);
            @(posedge clk); #1;
        end

        // Bare mode
        clear_mem();
        do_walk(1'b0, 22'h3FFFFF, 20'hABCDE, 0);
        check_eq("bare_pa", got_pa, 22'h0ABCDE);
        check_eq("bare_md", got_md, 8'hDF);

        // 4K walk, level-0 PTE placed at {0x100, vpn0=2, 00}
        clear_mem();
        mem_tbl[34'h0_0010_0004] = 32'h0004_0001;
        mem_tbl[34'h0_0010_0008] = 32'h1234_50CF;
        do_walk(1'b1, 22'h000100, {10'h001, 10'h002}, 0);
        check_eq("walk4k_pa", got_pa, 22'h048D14);
        check_eq("walk4k_md", got_md, 8'hCF);

        // Same walk with 3-cycle backpressure on every read
        do_walk(1'b1, 22'h000100, {10'h001, 10'h002}, 3);

        // Superpages: aligned then misaligned
        clear_mem();
        mem_tbl[34'h0_0010_000C] = 32'h8000_00CB;
        do_walk(1'b1, 22'h000100, {10'h003, 10'h155}, 0);
        check_eq("super_pa", got_pa, {12'h800, 10'h155});
        check_eq("super_md", got_md, 8'hCB);
        mem_tbl[34'h0_0010_000C] = 32'h8000_04CB;
        do_walk(1'b1, 22'h000100, {10'h003, 10'h155}, 0);
        check_eq("super_mis_pf", got_pf, 1'b1);

        // Faults: bus error at level 0, W without R, pointer at level 0
        clear_mem();
        mem_tbl[34'h0_0010_0004] = 32'h0004_0001;
        err_tbl[34'h0_0010_0008] = 1'b1;
        do_walk(1'b1, 22'h000100, {10'h001, 10'h002}, 0);
        check_eq("buserr_af", got_af, 1'b1);
        check_eq("buserr_pf", got_pf, 1'b0);
        clear_mem();
        mem_tbl[34'h0_0010_0004] = 32'h0000_0005;
        do_walk(1'b1, 22'h000100, {10'h001, 10'h002}, 0);
        check_eq("wnr_pf", got_pf, 1'b1);
        clear_mem();
        mem_tbl[34'h0_0010_0004] = 32'h0004_0001;
        mem_tbl[34'h0_0010_0008] = 32'h0000_0401;
        do_walk(1'b1, 22'h000100, {10'h001, 10'h002}, 0);
        check_eq("l0ptr_pf", got_pf, 1'b1);

        // Randomized walks over freshly generated tables
        for (int it = 0; it < 150; it++) begin
            clear_mem();
            ppn = 22'($urandom);
            vpn = 20'($urandom);
            a1 = 34'(ppn) * 34'd4096 + 34'(vpn / 1024) * 34'd4;
            k = $urandom_range(0, 9);
            p1 = rand_pte((k < 5) ? 0 : (k < 7) ? 1 : (k == 7) ? 2 : (k == 8) ? 3 : 4);
            mem_tbl[a1] = p1;
            if ($urandom_range(0, 9) == 0) err_tbl[a1] = 1'b1;
            if (p1[3:0] == 4'b0001) begin
                a0 = 34'(p1 / 1024) * 34'd4096 + 34'(vpn % 1024) * 34'd4;
                k = $urandom_range(0, 9);
                mem_tbl[a0] = rand_pte((k < 2) ? 0 : (k < 6) ? 1 : (k == 6) ? 2 : (k == 7) ? 3 : 4);
                if ($urandom_range(0, 9) == 0) err_tbl[a0] = 1'b1;
            end
            do_walk(($urandom_range(0, 4) != 0), ppn, vpn, -1);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
